sobel_window_sequencer: RTL and testbench

Sequences the Sobel operator's accesses to the shared grayscale frame memory. Once a frame has been written, it walks every interior pixel in row-major order. For each pixel it issues the nine 3x3 neighbourhood reads and presents the assembled window, plus the centre address, to the Gx/Gy compute stage over a valid/ready handshake. It also arbitrates the memory's single read port with the VGA display reader; VGA always has priority.

---
 rtl/sobel_window_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sobel_window_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_sequencer.sv
// sobel_window_sequencer
// Walks every interior pixel of a W x H grayscale frame in row-major order,
// reads the 3x3 neighbourhood of each through the shared single read port,
// and presents the assembled window plus centre address over valid/ready.
// The VGA reader always wins the read port; the sequencer simply stalls.

module sobel_window_sequencer #(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              vga_req,
  input  logic [AW-1:0]     vga_addr,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [9*DW-1:0]   win_pix,
  output logic [AW-1:0]     win_addr
);

  localparam int LW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [AW-1:0]    r_row;
  logic [AW-1:0]    r_col;
  logic [3:0]       r_k;
  logic [3:0]       r_k_d;
  logic             r_seq_issue_d;
  logic [9*DW-1:0]  r_win_pix;
  logic [AW-1:0]    r_win_addr;

  logic             w_seq_issue;
  logic [1:0]       w_dr;
  logic [1:0]       w_dc;
  logic [AW-1:0]    w_tap_row;
  logic [AW-1:0]    w_tap_col;
  logic [AW-1:0]    w_tap_addr;
  logic [AW-1:0]    w_centre_addr;
  logic             w_col_more;
  logic             w_row_more;

  // Tap index k -> (dr, dc) offset within the 3x3 neighbourhood.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_dr = 2'd0;
    w_dc = 2'd0;
    case (r_k)
      4'd0:    begin w_dr = 2'd0; w_dc = 2'd0; end
      4'd1:    begin w_dr = 2'd0; w_dc = 2'd1; end
      4'd2:    begin w_dr = 2'd0; w_dc = 2'd2; end
      4'd3:    begin w_dr = 2'd1; w_dc = 2'd0; end
      4'd4:    begin w_dr = 2'd1; w_dc = 2'd1; end
      4'd5:    begin w_dr = 2'd1; w_dc = 2'd2; end
      4'd6:    begin w_dr = 2'd2; w_dc = 2'd0; end
      4'd7:    begin w_dr = 2'd2; w_dc = 2'd1; end
      default: begin w_dr = 2'd2; w_dc = 2'd2; end
    endcase
  end

  // Address arithmetic; W is a power of two so row*W is a shift, truncated to AW.
  assign w_tap_row     = r_row + AW'(w_dr) - AW'(1);
  assign w_tap_col     = r_col + AW'(w_dc) - AW'(1);
  assign w_tap_addr    = (w_tap_row << LW) + w_tap_col;
  assign w_centre_addr = (r_row << LW) + r_col;
  assign w_col_more    = (r_col < AW'(W - 2));
  assign w_row_more    = (r_row < AW'(H - 2));

  // Read-port arbitration: VGA has absolute priority and needs no grant.
  assign w_seq_issue = (r_state == S_FETCH) && !vga_req;
  assign rd_en       = vga_req | w_seq_issue;
  assign rd_addr     = vga_req ? vga_addr : w_tap_addr;

  // Status and window outputs decode directly from state and held registers.
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign win_valid = (r_state == S_PRESENT);
  assign win_pix   = r_win_pix;
  assign win_addr  = r_win_addr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_FETCH;
      S_FETCH:   if (w_seq_issue && (r_k == 4'd8)) w_state_next = S_DRAIN;
      S_DRAIN:   w_state_next = S_PRESENT;
      S_PRESENT: begin
        if (win_ready) begin
          if (w_col_more || w_row_more) w_state_next = S_FETCH;
          else                          w_state_next = S_DONE;
        end
      end
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Tap issue tracking, window capture and centre-pixel walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row         <= AW'(1);
      r_col         <= AW'(1);
      r_k           <= 4'd0;
      r_k_d         <= 4'd0;
      r_seq_issue_d <= 1'b0;
      // NOTE: win_pix is a nine-entry flop bank, not a RAM, so it takes the async reset like any register.
      r_win_pix     <= '0;
      r_win_addr    <= '0;
    end else begin
      r_seq_issue_d <= w_seq_issue;
      r_k_d         <= r_k;

      // Data returns one cycle after issue; only sequencer-owned returns are captured.
      if (r_seq_issue_d) begin
        for (int k = 0; k < 9; k++) begin
          if (r_k_d == 4'(k)) r_win_pix[k*DW +: DW] <= rd_data;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row <= AW'(1);
            r_col <= AW'(1);
            r_k   <= 4'd0;
          end
        end
        S_FETCH: begin
          if (w_seq_issue) r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
        end
        S_DRAIN: begin
          r_win_addr <= w_centre_addr;
        end
        S_PRESENT: begin
          if (win_ready) begin
            if (w_col_more) begin
              r_col <= r_col + AW'(1);
            end else if (w_row_more) begin
              r_col <= AW'(1);
              r_row <= r_row + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Directed testbench for sobel_window_sequencer: reset, first window,
// VGA contention, backpressure, full frame pass and reset mid-fetch.

module tb_sobel_window_sequencer;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 10;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            vga_req = 1'b0;
  logic [AW-1:0]   vga_addr = '0;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data = '0;
  logic            win_valid;
  logic            win_ready = 1'b0;
  logic [9*DW-1:0] win_pix;
  logic [AW-1:0]   win_addr;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  sobel_window_sequencer #(.W(W), .H(H), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_pix   (win_pix),
    .win_addr  (win_addr)
  );

  always #5 clk = ~clk;

  // Frame memory: synchronous read, data valid one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Pattern 0: mem[a] = a[3:0]. Pattern 1: a[3:0] ^ a[8:5] so rows differ too.
  task automatic load_mem(input int pat);
    logic [AW-1:0] av;
    for (int a = 0; a < (1 << AW); a++) begin
      av = AW'(a);
      mem[a] = (pat == 0) ? av[3:0] : (av[3:0] ^ av[8:5]);
    end
  endtask

  function automatic logic [9*DW-1:0] model_pix(input int r, input int c);
    logic [9*DW-1:0] res;
    int a;
    res = '0;
    for (int k = 0; k < 9; k++) begin
      a = ((r - 1 + k / 3) * W + (c - 1 + k % 3)) & ((1 << AW) - 1);
      res[k*DW +: DW] = mem[a];
    end
    return res;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    start = 1'b0; vga_req = 1'b0; win_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    vga_req = 1'b1; vga_addr = 10'd500;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
    checks++; if (win_pix !== '0) begin errors++; $display("FAIL reset_win_pix: got %h want 0", win_pix); end
    checks++; if (win_addr !== '0) begin errors++; $display("FAIL reset_win_addr: got %0d want 0", win_addr); end
    checks++; if (rd_en !== 1'b1 || rd_addr !== 10'd500) begin errors++;
      $display("FAIL reset_vga_passthru: got rd_en=%b rd_addr=%0d want 1/500", rd_en, rd_addr); end
    vga_req = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_idle: got %b want 0", rd_en); end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (rd_en !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL post_reset_idle: got rd_en=%b busy=%b want 0/0", rd_en, busy); end
  endtask

  task automatic test_first_window();
    int exp_a[9] = '{0, 1, 2, 32, 33, 34, 64, 65, 66};
    int got_a[9];
    int n = 0;
    int lat = 0;
    bit found = 0;
    load_mem(0);
    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 40 && !found; cyc++) begin
      #1;
      if (cyc == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy_rise: got %b want 1", busy); end
      end
      if (rd_en) begin
        if (n < 9) got_a[n] = int'(rd_addr);
        n++;
      end
      if (win_valid) begin found = 1; lat = cyc; end
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL first_timeout: got no win_valid want window within 40 cycles"); end
    checks++; if (n !== 9) begin errors++; $display("FAIL first_read_count: got %0d want 9", n); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (got_a[i] !== exp_a[i]) begin errors++;
        $display("FAIL first_tap_addr[%0d]: got %0d want %0d", i, got_a[i], exp_a[i]); end
    end
    checks++; if (lat !== 11) begin errors++; $display("FAIL first_latency: got %0d want 11", lat); end
    checks++; if (win_addr !== 10'd33) begin errors++; $display("FAIL first_win_addr: got %0d want 33", win_addr); end
    checks++; if (win_pix !== 36'h210210210) begin errors++; $display("FAIL first_win_pix: got %h want 210210210", win_pix); end
  endtask

  // Continues straight into the second window (centre row 1, col 2).
  task automatic test_vga_contention();
    int exp_a[9] = '{1, 2, 3, 33, 34, 35, 65, 66, 67};
    int got_a[9];
    int n = 0;
    int lat = 0;
    int vga_bad = 0;
    bit found = 0;
    vga_addr = 10'd500;
    for (int cyc = 1; cyc <= 60 && !found; cyc++) begin
      @(negedge clk);
      vga_req = (cyc >= 4 && cyc <= 6);
      #1;
      if (vga_req) begin
        if (rd_en !== 1'b1 || rd_addr !== 10'd500) vga_bad++;
      end else if (rd_en) begin
        if (n < 9) got_a[n] = int'(rd_addr);
        n++;
      end
      if (win_valid) begin found = 1; lat = cyc; end
    end
    vga_req = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL vga_timeout: got no win_valid want window within 60 cycles"); end
    checks++; if (vga_bad !== 0) begin errors++; $display("FAIL vga_grant: got %0d bad cycles want 0", vga_bad); end
    checks++; if (n !== 9) begin errors++; $display("FAIL vga_read_count: got %0d want 9", n); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (got_a[i] !== exp_a[i]) begin errors++;
        $display("FAIL vga_tap_addr[%0d]: got %0d want %0d", i, got_a[i], exp_a[i]); end
    end
    checks++; if (lat !== 14) begin errors++; $display("FAIL vga_latency: got %0d want 14", lat); end
    checks++; if (win_addr !== 10'd34) begin errors++; $display("FAIL vga_win_addr: got %0d want 34", win_addr); end
    checks++; if (win_pix !== 36'h321321321) begin errors++; $display("FAIL vga_win_pix: got %h want 321321321", win_pix); end
  endtask

  // Third window (centre row 1, col 3) held for 20 cycles with win_ready low.
  task automatic test_backpressure();
    bit found = 0;
    int bad_v = 0;
    int bad_s = 0;
    int bad_r = 0;
    @(negedge clk);
    win_ready = 1'b0;
    for (int cyc = 1; cyc <= 40 && !found; cyc++) begin
      #1;
      if (win_valid) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL bp_timeout: got no win_valid want window within 40 cycles"); end
    vga_addr = 10'd777;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vga_req = (i == 5 || i == 6);
      #1;
      if (win_valid !== 1'b1) bad_v++;
      if (win_pix !== 36'h432432432 || win_addr !== 10'd35) bad_s++;
      if (rd_en !== vga_req) bad_r++;
      if (vga_req && rd_addr !== 10'd777) bad_r++;
    end
    vga_req = 1'b0;
    checks++; if (bad_v !== 0) begin errors++; $display("FAIL bp_valid_held: got %0d drop cycles want 0", bad_v); end
    checks++; if (bad_s !== 0) begin errors++; $display("FAIL bp_window_stable: got %0d unstable cycles want 0", bad_s); end
    checks++; if (bad_r !== 0) begin errors++; $display("FAIL bp_reads: got %0d stray read cycles want 0", bad_r); end
    win_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (win_valid !== 1'b0 || rd_en !== 1'b1 || rd_addr !== 10'd3) begin errors++;
      $display("FAIL bp_next_fetch: got valid=%b rd_en=%b rd_addr=%0d want 0/1/3", win_valid, rd_en, rd_addr); end
  endtask

  task automatic test_full_pass();
    int exp_r = 1;
    int exp_c = 1;
    int hs = 0;
    int bad_addr = 0;
    int bad_pix = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_addr = -1;
    logic busy_after = 1'bx;
    logic busy_mid = 1'bx;
    bit finished = 0;
    do_reset();
    load_mem(1);
    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 15000 && !finished; cyc++) begin
      start = (cyc == 500);
      #1;
      if (cyc == 500) busy_mid = busy;
      if (win_valid && win_ready) begin
        hs++;
        if (win_addr !== AW'(exp_r * W + exp_c)) bad_addr++;
        if (win_pix !== model_pix(exp_r, exp_c)) bad_pix++;
        last_addr = int'(win_addr);
        if (exp_c < W - 2) exp_c++;
        else begin exp_c = 1; exp_r++; end
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy;
      if (done_cnt > 0 && cyc == done_cyc + 5) finished = 1;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (!finished) begin errors++; $display("FAIL pass_timeout: got no completion want done within 15000 cycles"); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL pass_busy_mid: got %b want 1", busy_mid); end
    checks++; if (hs !== 900) begin errors++; $display("FAIL pass_handshakes: got %0d want 900", hs); end
    checks++; if (last_addr !== 990) begin errors++; $display("FAIL pass_last_addr: got %0d want 990", last_addr); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL pass_order: got %0d wrong centres want 0", bad_addr); end
    checks++; if (bad_pix !== 0) begin errors++; $display("FAIL pass_pixels: got %0d wrong windows want 0", bad_pix); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pass_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL pass_busy_fall: got %b want 0", busy_after); end
  endtask

  task automatic test_reset_mid_fetch();
    int lat = 0;
    bit found = 0;
    load_mem(0);
    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b done=%b want 0/0/0", busy, win_valid, done); end
    checks++; if (rd_en !== 1'b0 || win_addr !== '0 || win_pix !== '0) begin errors++;
      $display("FAIL midreset_clear: got rd_en=%b addr=%0d pix=%h want 0/0/0", rd_en, win_addr, win_pix); end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 40 && !found; cyc++) begin
      #1;
      if (win_valid) begin found = 1; lat = cyc; end
      else @(negedge clk);
    end
    checks++; if (!found || lat !== 11) begin errors++; $display("FAIL restart_latency: got %0d want 11", lat); end
    checks++; if (win_addr !== 10'd33) begin errors++; $display("FAIL restart_win_addr: got %0d want 33", win_addr); end
    checks++; if (win_pix !== 36'h210210210) begin errors++; $display("FAIL restart_win_pix: got %h want 210210210", win_pix); end
    // Reset while presenting: win_valid must drop in the same cycle.
    rst = 1'b1;
    #1;
    checks++; if (win_valid !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL present_reset: got valid=%b done=%b want 0/0", win_valid, done); end
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_window();
    test_vga_contention();
    test_backpressure();
    test_full_pass();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
